// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter.
// Size codes, FSM states and big-endian lane helper.
package dmem_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b11;
    localparam logic [1:0] SIZE_HALF = 2'b10;
    localparam logic [1:0] SIZE_BYTE = 2'b01;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } state_e;

    // Byte lane (counted from the LSB) holding the low byte of the access.
    function automatic logic [1:0] lane_index(
        input logic [1:0] size,
        input logic [1:0] addr_lo
    );
        logic [1:0] lane;
        lane = 2'd0;
        unique case (1'b1)
            size == SIZE_BYTE: lane = 2'd3 - addr_lo;
            size == SIZE_HALF: lane = addr_lo[1] ? 2'd0 : 2'd2;
            default:           lane = 2'd0;
        endcase
        return lane;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Big-endian lane steering for sub-word accesses.
// Merges store data into an old word and extracts load data.
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    output logic [31:0] new_word,
    output logic [31:0] rdata
);

    logic [4:0]  sh;
    logic [31:0] mask;

    always_comb begin
        sh   = {lane_index(size, addr_lo), 3'b000};
        mask = 32'hFFFF_FFFF;
        unique case (1'b1)
            size == SIZE_BYTE: mask = 32'h0000_00FF;
            size == SIZE_HALF: mask = 32'h0000_FFFF;
            default:           mask = 32'hFFFF_FFFF;
        endcase
        new_word = (old_word & ~(mask << sh)) | ((wdata & mask) << sh);
        rdata    = (old_word >> sh) & mask;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and access sequencer for the shared DataMemory.
// Handles read wait-states, sub-word read-modify-write and access checks.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int READ_WAIT = 1,
    parameter int MEM_BYTES = 4096
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [1:0]  m0_size,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [1:0]  m1_size,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam int CW = (READ_WAIT > 0) ? $clog2(READ_WAIT + 1) : 1;

    state_e         state_q;
    state_e         state_d;
    logic           rr_last_q;
    logic [CW-1:0]  cnt_q;
    logic           id_q;
    logic           we_q;
    logic [1:0]     size_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [31:0]    resp_q;
    logic           err_q;

    logic           grant;
    logic           pick;
    logic           sel_we;
    logic [1:0]     sel_size;
    logic [31:0]    sel_addr;
    logic [31:0]    sel_wdata;
    logic           sel_err;
    logic           rd_done;
    logic [31:0]    merged;
    logic [31:0]    extracted;

    dmem_lane_unit u_lane (
        .old_word (mem_read_data),
        .wdata    (wdata_q),
        .size     (size_q),
        .addr_lo  (addr_q[1:0]),
        .new_word (merged),
        .rdata    (extracted)
    );

    // Tie goes to whoever was not granted last.
    assign pick      = m1_req & (~m0_req | ~rr_last_q);
    assign grant     = (state_q == IDLE) & (m0_req | m1_req);
    assign sel_we    = pick ? m1_we    : m0_we;
    assign sel_size  = pick ? m1_size  : m0_size;
    assign sel_addr  = pick ? m1_addr  : m0_addr;
    assign sel_wdata = pick ? m1_wdata : m0_wdata;
    assign rd_done   = (state_q == RD) & (cnt_q == CW'(READ_WAIT));

    always_comb begin
        sel_err = 1'b0;
        if (sel_size == 2'b00)
            sel_err = 1'b1;
        if (sel_size == SIZE_HALF && sel_addr[0])
            sel_err = 1'b1;
        if (sel_size == SIZE_WORD && sel_addr[1:0] != 2'b00)
            sel_err = 1'b1;
        if (({1'b0, sel_addr[31:2], 2'b00} + 33'd3) >= 33'(MEM_BYTES))
            sel_err = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (grant) begin
                    if (sel_err)
                        state_d = RESP;
                    else if (!sel_we || sel_size != SIZE_WORD)
                        state_d = RD;
                    else
                        state_d = WR;
                end
            end
            RD: begin
                if (rd_done)
                    state_d = we_q ? WR : RESP;
            end
            WR:      state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            rr_last_q      <= 1'b1;
            cnt_q          <= '0;
            id_q           <= 1'b0;
            we_q           <= 1'b0;
            size_q         <= 2'b00;
            addr_q         <= '0;
            wdata_q        <= '0;
            resp_q         <= '0;
            err_q          <= 1'b0;
            mem_address    <= '0;
            mem_write_data <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                id_q           <= pick;
                rr_last_q      <= pick;
                we_q           <= sel_we;
                size_q         <= sel_size;
                addr_q         <= sel_addr;
                wdata_q        <= sel_wdata;
                err_q          <= sel_err;
                resp_q         <= '0;
                cnt_q          <= '0;
                mem_address    <= {sel_addr[31:2], 2'b00};
                mem_write_data <= sel_wdata;
            end
            if (state_q == RD) begin
                cnt_q <= rd_done ? '0 : cnt_q + 1'b1;
                if (rd_done) begin
                    if (we_q)
                        mem_write_data <= merged;
                    else
                        resp_q <= extracted;
                end
            end
        end
    end

    // Strobes follow state so reset drops them immediately.
    assign mem_read  = (state_q == RD);
    assign mem_write = (state_q == WR);

    assign m0_gnt    = grant & ~pick;
    assign m1_gnt    = grant & pick;
    assign m0_rvalid = (state_q == RESP) & ~id_q;
    assign m1_rvalid = (state_q == RESP) & id_q;
    assign m0_rdata  = m0_rvalid ? resp_q : 32'h0;
    assign m1_rdata  = m1_rvalid ? resp_q : 32'h0;
    assign m0_err    = m0_rvalid & err_q;
    assign m1_err    = m1_rvalid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a big-endian byte memory model.
// Vector table plus sequences for arbitration, hold-off and reset abort.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 0, m0_we = 0;
    logic [1:0]  m0_size = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic        m0_gnt, m0_rvalid, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 0, m1_we = 0;
    logic [1:0]  m1_size = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic        m1_gnt, m1_rvalid, m1_err;
    logic [31:0] m1_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read, mem_write;

    int n_checks = 0;
    int n_fail = 0;

    logic [7:0] mem [0:4095] = '{default: 8'h00};

    always #5 clk = ~clk;

    dmem_arbiter #(.READ_WAIT(1), .MEM_BYTES(4096)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_size(m0_size),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_gnt(m0_gnt),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_size(m1_size),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_gnt(m1_gnt),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_read_data(mem_read_data)
    );

    function automatic logic [31:0] word_at(input int a);
        return {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    assign mem_read_data = mem_read ?
        word_at(int'(mem_address[11:0])) : 32'h0;

    always @(negedge clk) begin
        if (mem_write) begin
            mem[int'(mem_address[11:0])]     <= mem_write_data[31:24];
            mem[int'(mem_address[11:0]) + 1] <= mem_write_data[23:16];
            mem[int'(mem_address[11:0]) + 2] <= mem_write_data[15:8];
            mem[int'(mem_address[11:0]) + 3] <= mem_write_data[7:0];
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input bit p, input logic req, input logic we,
                         input logic [1:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
        if (p) begin
            m1_req = req; m1_we = we; m1_size = sz;
            m1_addr = a; m1_wdata = wd;
        end else begin
            m0_req = req; m0_we = we; m0_size = sz;
            m0_addr = a; m0_wdata = wd;
        end
    endtask

    task automatic txn(input bit p, input logic we, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e,
                       output int lat, output int nrd, output int nwr,
                       output logic oth);
        int w;
        lat = -1; nrd = 0; nwr = 0; rd = 0; e = 0; oth = 0;
        @(negedge clk);
        drive(p, 1'b1, we, sz, a, wd);
        #1;
        w = 0;
        while (!(p ? m1_gnt : m0_gnt) && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(negedge clk);
        drive(p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        if (w >= 20) return;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (mem_read)  nrd++;
            if (mem_write) nwr++;
            if (p ? m1_rvalid : m0_rvalid) begin
                lat = c;
                rd  = p ? m1_rdata : m0_rdata;
                e   = p ? m1_err : m0_err;
                oth = p ? m0_rvalid : m1_rvalid;
                break;
            end
            @(negedge clk);
        end
    endtask

    typedef struct {
        bit          p;
        logic        we;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          nrd;
        int          nwr;
    } vec_t;

    vec_t vec [15];

    initial begin
        logic [31:0] rd;
        logic        e, oth;
        int          lat, nrd, nwr;
        int          r0, g1, ng, nr;
        bit          exp_port [4];
        bit          drop;

        vec[0]  = '{0, 1, 2'b11, 32'd4,    32'h01234567, 32'h0,        0, 2, 0, 1};
        vec[1]  = '{0, 0, 2'b11, 32'd4,    32'h0,        32'h01234567, 0, 3, 2, 0};
        vec[2]  = '{1, 1, 2'b01, 32'd6,    32'h000000AB, 32'h0,        0, 4, 2, 1};
        vec[3]  = '{1, 0, 2'b11, 32'd4,    32'h0,        32'h0123AB67, 0, 3, 2, 0};
        vec[4]  = '{0, 0, 2'b01, 32'd6,    32'h0,        32'h000000AB, 0, 3, 2, 0};
        vec[5]  = '{1, 0, 2'b10, 32'd4,    32'h0,        32'h00000123, 0, 3, 2, 0};
        vec[6]  = '{0, 1, 2'b10, 32'd6,    32'h0000BEEF, 32'h0,        0, 4, 2, 1};
        vec[7]  = '{0, 0, 2'b01, 32'd7,    32'h0,        32'h000000EF, 0, 3, 2, 0};
        vec[8]  = '{0, 0, 2'b11, 32'd2,    32'h0,        32'h0,        1, 1, 0, 0};
        vec[9]  = '{1, 1, 2'b10, 32'd5,    32'h1111,     32'h0,        1, 1, 0, 0};
        vec[10] = '{0, 0, 2'b00, 32'd8,    32'h0,        32'h0,        1, 1, 0, 0};
        vec[11] = '{1, 0, 2'b11, 32'd4092, 32'h0,        32'h0,        0, 3, 2, 0};
        vec[12] = '{0, 1, 2'b11, 32'd4096, 32'hCAFEF00D, 32'h0,        1, 1, 0, 0};
        vec[13] = '{1, 1, 2'b01, 32'd4095, 32'h1234565A, 32'h0,        0, 4, 2, 1};
        vec[14] = '{0, 0, 2'b11, 32'd4092, 32'h0,        32'h0000005A, 0, 3, 2, 0};

        // reset state
        #12;
        check("rst mem_read", {31'h0, mem_read}, 32'h0);
        check("rst mem_write", {31'h0, mem_write}, 32'h0);
        check("rst mem_address", mem_address, 32'h0);
        check("rst mem_write_data", mem_write_data, 32'h0);
        check("rst rvalid", {30'h0, m1_rvalid, m0_rvalid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            txn(vec[i].p, vec[i].we, vec[i].sz, vec[i].a, vec[i].wd,
                rd, e, lat, nrd, nwr, oth);
            check($sformatf("v%0d latency", i), lat, vec[i].lat);
            check($sformatf("v%0d rdata", i), rd, vec[i].rd);
            check($sformatf("v%0d err", i), {31'h0, e}, {31'h0, vec[i].e});
            check($sformatf("v%0d mem_read cycles", i), nrd, vec[i].nrd);
            check($sformatf("v%0d mem_write cycles", i), nwr, vec[i].nwr);
            check($sformatf("v%0d other rvalid", i), {31'h0, oth}, 32'h0);
        end
        check("mem word @4", word_at(4), 32'h0123BEEF);
        check("mem word @4092", word_at(4092), 32'h0000005A);

        // m1 waits through an m0 store and is granted at the next IDLE
        @(negedge clk);
        drive(0, 1, 1, 2'b11, 32'd12, 32'h11223344);
        #1;
        check("hold m0 gnt", {31'h0, m0_gnt}, 32'h1);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        drive(1, 1, 0, 2'b11, 32'd12, 32'h0);
        r0 = -1; g1 = -1;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (m0_rvalid) r0 = c;
            if (m1_gnt) begin
                g1 = c;
                break;
            end
            @(negedge clk);
        end
        check("hold m0 rvalid cycle", r0, 32'd2);
        check("hold m1 gnt cycle", g1, 32'd3);
        @(negedge clk);
        drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            #1;
            if (m1_rvalid) begin
                lat = c;
                rd = m1_rdata;
                break;
            end
            @(negedge clk);
        end
        check("hold m1 latency", lat, 32'd3);
        check("hold m1 rdata", rd, 32'h11223344);

        // reset during the write cycle of a word store
        @(negedge clk);
        drive(0, 1, 1, 2'b11, 32'd8, 32'hDEADBEEF);
        #1;
        check("abort gnt", {31'h0, m0_gnt}, 32'h1);
        @(posedge clk);
        #1;
        check("abort in WR", {31'h0, mem_write}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("abort mem_write drop", {31'h0, mem_write}, 32'h0);
        @(negedge clk);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort no write", word_at(8), 32'h0);
        check("abort mem_address", mem_address, 32'h0);
        check("abort outputs", {28'h0, mem_read, mem_write,
                                m1_rvalid, m0_rvalid}, 32'h0);

        // both request loads: grants alternate starting with m0
        exp_port = '{0, 1, 0, 1};
        ng = 0; nr = 0; drop = 0;
        @(negedge clk);
        drive(0, 1, 0, 2'b11, 32'd4, 32'h0);
        drive(1, 1, 0, 2'b11, 32'd12, 32'h0);
        for (int c = 0; c < 60 && nr < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (drop) begin
                drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
                drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
                drop = 0;
            end
            #1;
            if ((m0_gnt || m1_gnt) && ng < 4) begin
                check($sformatf("rr gnt %0d port", ng),
                      {31'h0, m1_gnt}, {31'h0, exp_port[ng]});
                ng++;
                if (ng == 4) drop = 1;
            end
            if ((m0_rvalid || m1_rvalid) && nr < 4) begin
                check($sformatf("rr rvalid %0d port", nr),
                      {30'h0, m1_rvalid, m0_rvalid},
                      exp_port[nr] ? 32'h2 : 32'h1);
                check($sformatf("rr rvalid %0d data", nr),
                      m0_rdata | m1_rdata,
                      exp_port[nr] ? 32'h11223344 : 32'h0123BEEF);
                nr++;
            end
        end
        check("rr completions", nr, 32'd4);
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        drive(1, 0, 0, 2'b00, 32'h0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
